// File: rtl/alu_vector_scanner_if.sv
// Vector/response bus between the ALU self-test scanner and the 4-bit ALU macro.
// The scanner is the master: it drives {op,b,a} and samples {cout,res}.
interface alu_vector_scanner_if;
    logic [3:0] vec_a;
    logic [3:0] vec_b;
    logic [1:0] vec_op;
    logic       vec_valid;
    logic [3:0] rsp_res;
    logic       rsp_cout;

    modport master (
        output vec_a, vec_b, vec_op, vec_valid,
        input  rsp_res, rsp_cout
    );

    modport slave (
        input  vec_a, vec_b, vec_op, vec_valid,
        output rsp_res, rsp_cout
    );
endinterface

// File: rtl/alu_vector_scanner.sv
// Exhaustive self-test scanner for the 4-bit ALU: walks all 1024 {op,b,a} vectors,
// compares each delayed response against a golden model, counts mismatches, latches the first.
module alu_vector_scanner #(
    parameter int RSP_LATENCY = 1,
    parameter int ERR_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    alu_vector_scanner_if.master   alu,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic [9:0]             first_fail,
    output logic                   ff_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic [9:0] vec;     // {op, b, a}
    } stage_t;

    localparam logic [1:0]       DRAIN_LAST = 2'(RSP_LATENCY - 1);
    localparam logic [ERR_W-1:0] ERR_MAX    = '1;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] idx;
    logic [1:0] drain_cnt;
    stage_t     dly [RSP_LATENCY];
    stage_t     tail;
    logic       start_acc;
    logic       abort_acc;
    logic       mismatch;

    function automatic logic [4:0] golden(input logic [9:0] v);
        logic [3:0] a;
        logic [3:0] b;
        a = v[3:0];
        b = v[7:4];
        case (v[9:8])
            2'b00:   golden = {1'b0, a} + {1'b0, b};
            2'b01:   golden = {1'b0, a} - {1'b0, b};
            2'b10:   golden = {1'b0, a & b};
            default: golden = {1'b0, a | b};
        endcase
    endfunction

    assign start_acc = start && (state == IDLE || state == DONE);
    assign abort_acc = abort && (state == RUN || state == DRAIN);
    assign tail      = dly[RSP_LATENCY-1];
    assign mismatch  = tail.valid && ({alu.rsp_cout, alu.rsp_res} != golden(tail.vec));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (abort) state_nxt = IDLE;
                     else if (idx == 10'd1023) state_nxt = DRAIN;
            DRAIN:   if (abort) state_nxt = IDLE;
                     else if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        alu.vec_valid = 1'b0;
        alu.vec_a     = '0;
        alu.vec_b     = '0;
        alu.vec_op    = '0;
        unique case (state)
            RUN: begin
                busy          = 1'b1;
                alu.vec_valid = 1'b1;
                alu.vec_a     = idx[3:0];
                alu.vec_b     = idx[7:4];
                alu.vec_op    = idx[9:8];
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        pass = done && (err_count == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            drain_cnt  <= '0;
            err_count  <= '0;
            first_fail <= '0;
            ff_valid   <= 1'b0;
            // NOTE: the delay line is reset like plain flops; stale valid bits would trigger false compares.
            for (int i = 0; i < RSP_LATENCY; i++) dly[i] <= '0;
        end else begin
            if (start_acc || abort_acc) idx <= '0;
            else if (state == RUN)      idx <= idx + 10'd1;

            drain_cnt <= (state == DRAIN && !abort_acc) ? drain_cnt + 2'd1 : 2'd0;

            if (abort_acc) begin
                for (int i = 0; i < RSP_LATENCY; i++) dly[i] <= '0;
            end else begin
                dly[0] <= '{valid: (state == RUN), vec: idx};
                for (int i = 1; i < RSP_LATENCY; i++) dly[i] <= dly[i-1];
            end

            if (start_acc) begin
                err_count  <= '0;
                first_fail <= '0;
                ff_valid   <= 1'b0;
            end else if (mismatch) begin
                if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
                if (!ff_valid) begin
                    first_fail <= tail.vec;
                    ff_valid   <= 1'b1;
                end
            end
        end
    end

endmodule
